// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divide sequencer.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int DIV_WIDTH_DEF = 32;
    localparam int DIV_FN_W      = 64;

    // Two's-complement negate when neg is set; callers truncate to their width.
    function automatic logic [DIV_FN_W-1:0] cond_neg(input logic [DIV_FN_W-1:0] v,
                                                     input logic                neg);
        if (neg) begin
            return ~v + 64'd1;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/div_seq_step.sv
// One radix-2 restoring division step on {rem, quo} against the divisor magnitude.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted_s;
    logic [WIDTH:0] trial_s;

    // Shift, trial-subtract, and keep or restore the partial remainder.
    always_comb begin
        shifted_s = {rem, quo[WIDTH-1]};
        trial_s   = shifted_s - {1'b0, divisor};
        if (!trial_s[WIDTH]) begin
            rem_next = trial_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted_s[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_seq.sv
// Iterative DIV/DIVU sequencer with pipeline stall and flush cancel.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes straight from IDLE.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEF,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cancel_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    div_state_e       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r, quo_r, bmag_r, a_r, hi_r, lo_r;
    logic             qneg_r, rneg_r, done_r;

    logic [WIDTH-1:0] rem_nx_s, quo_nx_s, amag_s, bmag_s, hi_fin_s, lo_fin_s;
    logic             a_neg_s, b_neg_s, accept_s, stall_s, fast_zero_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .divisor  (bmag_r),
        .rem_next (rem_nx_s),
        .quo_next (quo_nx_s)
    );

    // Operand magnitudes, accept/stall decode and optional zero-divisor shortcut.
    always_comb begin
        a_neg_s  = signed_i & a_i[WIDTH-1];
        b_neg_s  = signed_i & b_i[WIDTH-1];
        amag_s   = WIDTH'(cond_neg(DIV_FN_W'(a_i), a_neg_s));
        bmag_s   = WIDTH'(cond_neg(DIV_FN_W'(b_i), b_neg_s));
        accept_s = (state_r == IDLE) & start_i & ~cancel_i;
        stall_s  = rst & (accept_s | (state_r == RUN) | (state_r == SIGN));
`ifdef DIV_ZERO_FAST_EN
        fast_zero_s = (b_i == {WIDTH{1'b0}});
`else
        fast_zero_s = 1'b0;
`endif
    end

    // Final sign fix-up; a zero divisor overrides with dividend / all ones.
    always_comb begin
        if (bmag_r == {WIDTH{1'b0}}) begin
            hi_fin_s = a_r;
            lo_fin_s = {WIDTH{1'b1}};
        end else begin
            hi_fin_s = WIDTH'(cond_neg(DIV_FN_W'(rem_r), rneg_r));
            lo_fin_s = WIDTH'(cond_neg(DIV_FN_W'(quo_r), qneg_r));
        end
    end

    // Sequencer FSM and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            bmag_r  <= {WIDTH{1'b0}};
            a_r     <= {WIDTH{1'b0}};
            qneg_r  <= 1'b0;
            rneg_r  <= 1'b0;
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (accept_s && fast_zero_s) begin
                        hi_r    <= a_i;
                        lo_r    <= {WIDTH{1'b1}};
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else if (accept_s) begin
                        a_r     <= a_i;
                        bmag_r  <= bmag_s;
                        qneg_r  <= a_neg_s ^ b_neg_s;
                        rneg_r  <= a_neg_s;
                        rem_r   <= {WIDTH{1'b0}};
                        quo_r   <= amag_s;
                        cnt_r   <= CNT_W'(WIDTH - 1);
                        state_r <= RUN;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (cancel_i) begin
                        state_r <= IDLE;
                    end else begin
                        rem_r <= rem_nx_s;
                        quo_r <= quo_nx_s;
                        if (cnt_r == {CNT_W{1'b0}}) begin
                            state_r <= SIGN;
                        end else begin
                            cnt_r <= cnt_r - CNT_W'(1);
                        end
                    end
                end
                SIGN: begin
                    if (cancel_i) begin
                        state_r <= IDLE;
                    end else begin
                        hi_r    <= hi_fin_s;
                        lo_r    <= lo_fin_s;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign stall_o = stall_s;
    assign busy_o  = (state_r != IDLE);
    assign done_o  = done_r;
    assign hi_o    = hi_r;
    assign lo_o    = lo_r;

endmodule

// File: doc/div_seq.md
# div_seq

Iterative divide sequencer for the pipelined MIPS core. It accepts a DIV/DIVU from the EX stage, runs a radix-2 restoring division over WIDTH cycles, and stalls the pipeline while it runs. It returns quotient (LO) and remainder (HI) to the datapath for the normal HI/LO writeback path. It also owns cancellation on a pipeline flush, so the controller never sees a partial result.

## Interface
Parameters:
- WIDTH, 32, operand/result width; an even value ≥ 4 is required
- CNT_W, $clog2(WIDTH), iteration counter width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  divide request from EX (isdivE, already qualified by the controller); held high while stalled
- signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i
- a_i  in  WIDTH  dividend; sampled on accept
- b_i  in  WIDTH  divisor; sampled on accept
- cancel_i  in  1  flush of the EX instruction; aborts any operation
- stall_o  out  1  to the hazard unit; holds IF/ID/EX while the divide is outstanding
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle pulse; hi_o/lo_o are valid in this cycle
- hi_o  out  WIDTH  remainder
- lo_o  out  WIDTH  quotient

## Operation
- States: IDLE, RUN, SIGN, DONE.
- **IDLE → RUN:** on start_i & !cancel_i.
  - Latch the divisor magnitude and the sign flags (sign(a)^sign(b) for the quotient, sign(a) for the remainder).
  - Load the partial remainder with 0 and the quotient register with |a|.
  - Set the counter to WIDTH-1.
- **RUN:** one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract |b|, using a WIDTH+1-bit subtract.
  - If non-negative, keep the difference and set quo[0]=1; otherwise restore and set quo[0]=0.
  - At counter 0, go to SIGN.
- **SIGN:** apply the sign rules.
  - Negate the quotient if the quotient sign is set and signed_i was latched.
  - Negate the remainder if the dividend was negative.
  - Then go to DONE.
- **DONE:** done_o=1, hi_o/lo_o hold the final values, then return to IDLE.
- Results stay registered until the next accept or reset.
- Arithmetic is modulo 2^WIDTH:
  - 0x80000000 / -1 signed gives LO=0x80000000 and HI=0 (no trap).
  - The remainder takes the sign of the dividend.
- Divide by zero: HI = original dividend, LO = all ones, for signed and unsigned operands. The SIGN state forces these values when the latched divisor is 0.
- **Cancel:** cancel_i in RUN/SIGN/DONE forces IDLE on the next edge.
  - No done_o is produced, and hi_o/lo_o keep their prior values.
  - In IDLE, cancel_i blocks the accept.
- **Reset:** rst low at any time gives state IDLE, counter 0, hi_o=lo_o=0, done_o=0, stall_o=0, busy_o=0.

## Timing
- Cycle 0 is the IDLE cycle with start_i high. The operation is accepted at the end of cycle 0.
- RUN covers cycles 1..WIDTH, SIGN is cycle WIDTH+1, and DONE is cycle WIDTH+2.
- stall_o is combinational: (IDLE & start_i & !cancel_i) | RUN | SIGN.
  - It is low in DONE, so EX captures hi_o/lo_o and advances on that edge.
- start_i is still high in DONE (same instruction). DONE never re-accepts it.
- A back-to-back divide is accepted from IDLE in the next cycle.
- Total stall: WIDTH+2 cycles per divide.

## Configuration
- DIV_ZERO_FAST_EN defined: in IDLE with start_i & b_i==0, the block goes directly to DONE.
  - Results are the same as the normal divide-by-zero case.
  - done_o appears in cycle 1, and stall_o is high in cycle 0 only.
- DIV_ZERO_FAST_EN undefined: divide by zero takes the full WIDTH+2 latency with identical results.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, RUN, SIGN, DONE)
  - a DIV_WIDTH_DEF=32 constant
  - a function for two's-complement negate/abs
- Sub-module div_step: one combinational restoring step.
  - Inputs: {rem, quo}, |b|.
  - Outputs: the next {rem, quo}.
  - Instantiated once and iterated by the FSM.

## Test plan
- Unsigned 100 / 7 → done_o in cycle 34, LO=0x0000000E, HI=0x00000002; stall_o high for cycles 0–33.
- Signed -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; signed 7 / -2 → LO=0xFFFFFFFD, HI=0x00000001.
- Signed 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0; unsigned 0xFFFFFFFF / 1 → LO=0xFFFFFFFF, HI=0.
- 0x12345678 / 0 (both signedness) → HI=0x12345678, LO=0xFFFFFFFF.
  - With DIV_ZERO_FAST_EN: done_o in cycle 1.
  - Without it: done_o in cycle 34.
- cancel_i in RUN cycle 10 → no done_o, stall_o low from cycle 11, hi_o/lo_o unchanged; a fresh 9/3 then gives LO=3, HI=0.
- Two back-to-back divides (start_i held through DONE) → exactly two done_o pulses, 35 cycles apart.
- rst pulse mid-RUN → all outputs 0 asynchronously.
